// File: rtl/prestore_capture_pkg.sv
// Shared types and constants for the prestore capture stage.
// Nibble layout and FSM state encoding live here so the packer and top agree.
package prestore_capture_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_EPOCH,
        FILL,
        DONE
    } cap_state_t;

    localparam int NIBBLE_W  = 4;
    localparam int I_SIG_BIT = 0;
    localparam int I_MAG_BIT = 1;
    localparam int Q_SIG_BIT = 2;
    localparam int Q_MAG_BIT = 3;

    function automatic logic [NIBBLE_W-1:0] make_nibble(
        input logic i_sig,
        input logic i_mag,
        input logic q_sig,
        input logic q_mag
    );
        logic [NIBBLE_W-1:0] n;
        n            = '0;
        n[I_SIG_BIT] = i_sig;
        n[I_MAG_BIT] = i_mag;
        n[Q_SIG_BIT] = q_sig;
        n[Q_MAG_BIT] = q_mag;
        return n;
    endfunction

endpackage

// File: rtl/prestore_word_packer.sv
// Collects WORD_W/4 nibbles into one word, first nibble at the LSB.
// out_valid/word are combinational: they flag the nibble that completes a word.
module prestore_word_packer
    import prestore_capture_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                in_valid,
    input  logic [NIBBLE_W-1:0] nibble,
    output logic                out_valid,
    output logic [WORD_W-1:0]   word
);

    localparam int SPW   = WORD_W / NIBBLE_W;
    localparam int CNT_W = (SPW > 1) ? $clog2(SPW) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SPW - 1);

    // Holds the SPW-1 earlier samples; the newest nibble enters at the top.
    logic [WORD_W-NIBBLE_W-1:0] shreg;
    logic [CNT_W-1:0]           cnt;

    assign out_valid = in_valid && (cnt == LAST);
    assign word      = {nibble, shreg};

    // NOTE: the shift register is cleared on reset only for deterministic
    // simulation; a partial word is never exposed, so this is not functional.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (clear) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (in_valid) begin
            shreg <= word[WORD_W-1:NIBBLE_W];
            cnt   <= out_valid ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/prestore_capture.sv
// Captures prestore strobes as nibbles, packs them into words and writes one
// record of n_words words to the sample RAM, optionally aligned to ms_epoch.
module prestore_capture
    import prestore_capture_pkg::*;
#(
    parameter int WORD_W     = 32,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ms_epoch,
    input  logic                  valid,
    input  logic                  I_sum_sig,
    input  logic                  I_sum_mag,
    input  logic                  Q_sum_sig,
    input  logic                  Q_sum_mag,
    input  logic                  arm,
    input  logic                  abort,
    input  logic                  sync_mode,
    input  logic [DEPTH_LOG2:0]   n_words,
    output logic                  mem_we,
    output logic [DEPTH_LOG2-1:0] mem_addr,
    output logic [WORD_W-1:0]     mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic [DEPTH_LOG2:0]   word_cnt,
    output logic [15:0]           epoch_cnt
);

    localparam logic [DEPTH_LOG2:0] MAX_WORDS = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] CNT_ONE   = {{DEPTH_LOG2{1'b0}}, 1'b1};

    cap_state_t            state;
    logic [DEPTH_LOG2:0]   rec_len;
    logic [DEPTH_LOG2:0]   word_cnt_inc;
    logic [NIBBLE_W-1:0]   nibble;
    logic                  pack_clear;
    logic                  pack_in_valid;
    logic                  word_ready;
    logic [WORD_W-1:0]     packed_word;

    assign nibble        = make_nibble(I_sum_sig, I_sum_mag, Q_sum_sig, Q_sum_mag);
    // A sample arriving together with arm/abort belongs to no record.
    assign pack_clear    = arm || abort;
    assign pack_in_valid = (state == FILL) && valid && !arm && !abort;
    assign word_cnt_inc  = word_cnt + CNT_ONE;

    prestore_word_packer #(
        .WORD_W (WORD_W)
    ) u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (pack_clear),
        .in_valid  (pack_in_valid),
        .nibble    (nibble),
        .out_valid (word_ready),
        .word      (packed_word)
    );

    // NOTE: abort is tested before arm so that a simultaneous pair cancels.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rec_len   <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            word_cnt  <= '0;
            epoch_cnt <= '0;
        end else begin
            mem_we <= 1'b0;
            if (abort) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b0;
            end else if (arm) begin
                rec_len   <= (n_words == '0 || n_words > MAX_WORDS) ? MAX_WORDS : n_words;
                state     <= sync_mode ? WAIT_EPOCH : FILL;
                busy      <= 1'b1;
                done      <= 1'b0;
                word_cnt  <= '0;
                epoch_cnt <= '0;
                mem_addr  <= '0;
            end else begin
                case (state)
                    WAIT_EPOCH: begin
                        if (ms_epoch) state <= FILL;
                    end
                    FILL: begin
                        if (ms_epoch && epoch_cnt != 16'hFFFF) epoch_cnt <= epoch_cnt + 16'd1;
                        if (word_ready) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= word_cnt[DEPTH_LOG2-1:0];
                            mem_wdata <= packed_word;
                            word_cnt  <= word_cnt_inc;
                            if (word_cnt_inc == rec_len) begin
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prestore_capture.sv
// Directed bench for prestore_capture with a queue-based record model checked
// every cycle, plus literal expectations for each scenario.
module tb_prestore_capture;

    localparam int WW = 32;
    localparam int DL = 4;
    localparam int S_IDLE = 0, S_WAIT = 1, S_FILL = 2, S_DONE = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          ms_epoch = 1'b0;
    logic          valid = 1'b0;
    logic [3:0]    nib = 4'h0;
    logic          arm = 1'b0;
    logic          abort = 1'b0;
    logic          sync_mode = 1'b0;
    logic [DL:0]   n_words = '0;
    logic          mem_we;
    logic [DL-1:0] mem_addr;
    logic [WW-1:0] mem_wdata;
    logic          busy;
    logic          done;
    logic [DL:0]   word_cnt;
    logic [15:0]   epoch_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    prestore_capture #(
        .WORD_W     (WW),
        .DEPTH_LOG2 (DL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ms_epoch  (ms_epoch),
        .valid     (valid),
        .I_sum_sig (nib[0]),
        .I_sum_mag (nib[1]),
        .Q_sum_sig (nib[2]),
        .Q_sum_mag (nib[3]),
        .arm       (arm),
        .abort     (abort),
        .sync_mode (sync_mode),
        .n_words   (n_words),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .word_cnt  (word_cnt),
        .epoch_cnt (epoch_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural record model ----------------
    int          m_state = S_IDLE;
    logic [3:0]  m_q[$];
    bit          m_we = 1'b0;
    int          m_addr = 0;
    logic [31:0] m_data = '0;
    int          m_cnt = 0;
    int          m_ep = 0;
    int          m_len = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_state = S_IDLE; m_q.delete(); m_we = 0; m_addr = 0;
            m_data = '0; m_cnt = 0; m_ep = 0; m_len = 0;
        end else begin
            m_we = 0;
            if (abort) begin
                m_state = S_IDLE;
                m_q.delete();
            end else if (arm) begin
                m_len   = (n_words == 0 || int'(n_words) > (1 << DL)) ? (1 << DL) : int'(n_words);
                m_state = sync_mode ? S_WAIT : S_FILL;
                m_q.delete();
                m_cnt = 0; m_ep = 0; m_addr = 0;
            end else if (m_state == S_WAIT) begin
                if (ms_epoch) m_state = S_FILL;
            end else if (m_state == S_FILL) begin
                if (ms_epoch && m_ep < 65535) m_ep++;
                if (valid) begin
                    m_q.push_back(nib);
                    if (m_q.size() == WW / 4) begin
                        m_data = '0;
                        foreach (m_q[k]) m_data = m_data | (32'(m_q[k]) << (4 * k));
                        m_q.delete();
                        m_we = 1; m_addr = m_cnt; m_cnt++;
                        if (m_cnt == m_len) m_state = S_DONE;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        check("mem_we", 32'(mem_we), m_we ? 32'd1 : 32'd0);
        check("mem_addr", 32'(mem_addr), 32'(m_addr));
        if (m_we) check("mem_wdata", mem_wdata, m_data);
        check("busy", 32'(busy), (m_state == S_WAIT || m_state == S_FILL) ? 32'd1 : 32'd0);
        check("done", 32'(done), (m_state == S_DONE) ? 32'd1 : 32'd0);
        check("word_cnt", 32'(word_cnt), 32'(m_cnt));
        check("epoch_cnt", 32'(epoch_cnt), 32'(m_ep));
    end

    // ---------------- write log for literal checks ----------------
    typedef struct {
        int          addr;
        logic [31:0] data;
        logic        dn;
    } wr_t;
    wr_t wr_q[$];

    always @(negedge clk) begin
        if (mem_we) wr_q.push_back('{int'(mem_addr), mem_wdata, done});
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input logic v, input logic [3:0] n, input logic ep);
        valid = v; nib = n; ms_epoch = ep;
        @(posedge clk); #2;
        valid = 1'b0; ms_epoch = 1'b0;
    endtask

    task automatic idle(input int k);
        repeat (k) step(1'b0, 4'h0, 1'b0);
    endtask

    task automatic do_arm(input logic s, input logic [DL:0] n);
        arm = 1'b1; sync_mode = s; n_words = n;
        @(posedge clk); #2;
        arm = 1'b0;
    endtask

    initial begin
        // Reset state
        #1 reset = 1'b1;
        #10;
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_word_cnt", 32'(word_cnt), 32'd0);
        @(posedge clk); #2 reset = 1'b0;
        idle(2);

        // Immediate mode, two words back to back
        wr_q.delete();
        do_arm(1'b0, 5'd2);
        for (int i = 0; i < 16; i++) step(1'b1, 4'((i + 1) & 15), 1'b0);
        idle(2);
        for (int i = 0; i < 8; i++) step(1'b1, 4'h7, 1'b0);
        idle(2);
        check("imm_nwr", 32'(wr_q.size()), 32'd2);
        if (wr_q.size() == 2) begin
            check("imm_a0", 32'(wr_q[0].addr), 32'd0);
            check("imm_d0", wr_q[0].data, 32'h87654321);
            check("imm_a1", 32'(wr_q[1].addr), 32'd1);
            check("imm_d1", wr_q[1].data, 32'h0FEDCBA9);
            check("imm_done_at_wr", 32'(wr_q[1].dn), 32'd1);
        end

        // Sync mode: valids before the epoch are ignored
        wr_q.delete();
        do_arm(1'b1, 5'd1);
        for (int i = 0; i < 49; i++) step(1'b1, 4'hA, 1'b0);
        check("sync_busy", 32'(busy), 32'd1);
        check("sync_nocap", 32'(wr_q.size()), 32'd0);
        step(1'b1, 4'hF, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, 4'h0, 1'b0);
        idle(2);
        check("sync_nwr", 32'(wr_q.size()), 32'd1);
        if (wr_q.size() == 1) check("sync_d0", wr_q[0].data, 32'h00000000);
        check("sync_epoch", 32'(epoch_cnt), 32'd0);

        // Sparse valids with epochs during FILL
        wr_q.delete();
        do_arm(1'b0, 5'd1);
        for (int k = 0; k < 8; k++) begin
            for (int c = 0; c < 20; c++) begin
                if (k == 7 && c == 19) check("sparse_we_before", 32'(mem_we), 32'd0);
                step(c == 19, 4'(k + 1), (k == 1 && c == 5) || (k == 4 && c == 10) || (k == 7 && c == 19));
            end
        end
        check("sparse_we_after", 32'(mem_we), 32'd1);
        idle(2);
        step(1'b0, 4'h0, 1'b1);
        idle(2);
        check("sparse_epoch", 32'(epoch_cnt), 32'd3);
        check("sparse_nwr", 32'(wr_q.size()), 32'd1);
        if (wr_q.size() == 1) check("sparse_d0", wr_q[0].data, 32'h87654321);

        // Re-arm after a partial word
        wr_q.delete();
        do_arm(1'b0, 5'd1);
        for (int i = 0; i < 5; i++) step(1'b1, 4'(i + 1), 1'b0);
        do_arm(1'b0, 5'd1);
        for (int i = 0; i < 8; i++) step(1'b1, 4'(8 - i), 1'b0);
        idle(2);
        check("rearm_nwr", 32'(wr_q.size()), 32'd1);
        if (wr_q.size() == 1) begin
            check("rearm_a0", 32'(wr_q[0].addr), 32'd0);
            check("rearm_d0", wr_q[0].data, 32'h12345678);
        end

        // Abort and arm together while filling
        wr_q.delete();
        do_arm(1'b0, 5'd2);
        for (int i = 0; i < 3; i++) step(1'b1, 4'h5, 1'b0);
        arm = 1'b1; abort = 1'b1; n_words = 5'd1;
        step(1'b1, 4'h5, 1'b0);
        arm = 1'b0; abort = 1'b0;
        for (int i = 0; i < 16; i++) step(1'b1, 4'h6, 1'b0);
        idle(2);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_nwr", 32'(wr_q.size()), 32'd0);

        // Full depth via n_words = 0
        wr_q.delete();
        do_arm(1'b0, 5'd0);
        for (int i = 0; i < 128; i++) step(1'b1, 4'((i * 7 + 3) & 15), 1'b0);
        idle(2);
        check("full_nwr", 32'(wr_q.size()), 32'd16);
        check("full_word_cnt", 32'(word_cnt), 32'd16);
        check("full_done", 32'(done), 32'd1);
        if (wr_q.size() == 16) begin
            for (int i = 0; i < 16; i++) check("full_addr", 32'(wr_q[i].addr), 32'(i));
            check("full_last_done", 32'(wr_q[15].dn), 32'd1);
        end
        for (int i = 0; i < 8; i++) step(1'b1, 4'h1, 1'b0);
        idle(2);
        check("full_no_extra", 32'(wr_q.size()), 32'd16);
        abort = 1'b1; step(1'b0, 4'h0, 1'b0); abort = 1'b0;
        check("abort_clears_done", 32'(done), 32'd0);

        // Asynchronous reset during FILL
        do_arm(1'b0, 5'd2);
        for (int i = 0; i < 10; i++) step(1'b1, 4'h3, 1'b0);
        check("pre_rst_busy", 32'(busy), 32'd1);
        check("pre_rst_cnt", 32'(word_cnt), 32'd1);
        reset = 1'b1;
        #1;
        check("arst_we", 32'(mem_we), 32'd0);
        check("arst_addr", 32'(mem_addr), 32'd0);
        check("arst_wdata", mem_wdata, 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_cnt", 32'(word_cnt), 32'd0);
        check("arst_epoch", 32'(epoch_cnt), 32'd0);
        @(posedge clk); #2 reset = 1'b0;
        wr_q.delete();
        do_arm(1'b0, 5'd1);
        for (int i = 0; i < 8; i++) step(1'b1, 4'hC, 1'b0);
        idle(2);
        check("post_rst_nwr", 32'(wr_q.size()), 32'd1);
        if (wr_q.size() == 1) check("post_rst_d0", wr_q[0].data, 32'hCCCCCCCC);
        check("post_rst_done", 32'(done), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
